mem_farm_sched: RTL and testbench
=================================

MEM_FARM_SCHED -- requirements
Module: mem_farm_sched

Interface
REQ-001 SHALL have parameter NUM_CLIENTS, default 5: number of requesting clients (2..16).
REQ-002 SHALL have parameter NUM_BANKS, default 16: SRAM banks, power of 2 (2..32).
REQ-003 SHALL have parameter ADDR_W, default 19: byte-address width.
REQ-004 SHALL have parameter LEN_W, default 16: request length width, in bytes.
REQ-005 SHALL have one clock and a synchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset.
REQ-006 SHALL have ports req_valid  in  NUM_CLIENTS  per-client request; req_ready  out  NUM_CLIENTS  one-hot acceptance.
REQ-007 SHALL have ports req_write  in  NUM_CLIENTS  1=write, 0=read; req_addr  in  NUM_CLIENTS x ADDR_W  start byte address, 32-byte aligned; req_len  in  NUM_CLIENTS x LEN_W  length in bytes.
REQ-008 SHALL have ports prio_mode  in  1  0=fixed, 1=round-robin; client_priority  in  clog2(NUM_CLIENTS)  highest-priority client in fixed mode.
REQ-009 SHALL have ports beat_valid  out  1; beat_ready  in  1; beat_client  out  clog2(NUM_CLIENTS); beat_write  out  1; beat_bank  out  clog2(NUM_BANKS); beat_row  out  ADDR_W-5-clog2(NUM_BANKS); beat_bytes  out  6  valid bytes 1..32; beat_last  out  1.
REQ-010 SHALL have ports done  out  NUM_CLIENTS  one-cycle completion pulse; busy  out  1  FSM not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, BURST, DONE; one request is served at a time.
REQ-012 In IDLE with any req_valid high, SHALL assert req_ready for exactly one granted client for one cycle, latch its write/addr/len/index, go BURST (or DONE if req_len==0).
REQ-013 Fixed mode: grant the first valid client scanning upward from client_priority, wrapping modulo NUM_CLIENTS.
REQ-014 Round-robin mode: same scan from rr_ptr; rr_ptr SHALL update to (served client+1) mod NUM_CLIENTS in DONE, in either mode.
REQ-015 prio_mode/client_priority changes SHALL take effect only at the next IDLE arbitration.
REQ-016 Address map: beat index = addr>>5; beat_bank = index mod NUM_BANKS; beat_row = index / NUM_BANKS; low 5 address bits ignored.
REQ-017 Beats = ceil(len/32); every beat has beat_bytes=32 except the last, which has len mod 32 (32 if zero).
REQ-018 In BURST beat_valid SHALL be 1; a beat advances only on beat_valid&&beat_ready; beat_* SHALL hold stable while beat_ready is low.
REQ-019 On advance, bank SHALL increment; bank wrap NUM_BANKS-1->0 SHALL increment row; row overflow SHALL wrap to 0.
REQ-020 beat_last SHALL be 1 only on the final beat; its handshake moves FSM to DONE.
REQ-021 DONE SHALL pulse done[client] for one cycle, then return to IDLE; no req_ready in DONE.
REQ-022 Latency: acceptance at cycle T, first beat_valid at T+1; done at cycle after last handshake; next acceptance earliest the cycle after done.
REQ-023 Throughput SHALL be one beat per cycle with beat_ready held high.
REQ-024 req_valid dropped by a client before grant SHALL be ignored without error; requests are not queued.

Reset
REQ-025 When rst_n=0 at a rising edge: FSM=IDLE, rr_ptr=0, all outputs 0 (req_ready, done, beat_valid, beat_last, busy, beat_* fields).
REQ-026 Reset mid-burst SHALL abandon the request with no done pulse; first post-reset cycle behaves as fresh IDLE.

Verification
REQ-027 Client 2 addr 0x00040 len 70, beat_ready=1 -> accept T, beats T+1..T+3: bank 2,3,4 row 0, bytes 32,32,6, last on 3rd; done[2] at T+4.
REQ-028 NUM_BANKS=16, addr 0x001E0 len 64 -> beats bank 15 row 0, then bank 0 row 1.
REQ-029 Fixed mode, client_priority=3, req_valid=5'b10011 -> client 4 granted; round-robin after serving 4 -> client 0 next, then 1.
REQ-030 beat_ready toggled 1,0,0,1 during 3-beat burst -> beat fields stable while low; exactly 3 handshakes, one done pulse.
REQ-031 req_len=0 on client 1 -> req_ready[1] then done[1] next cycle, no beat_valid.
REQ-032 rst_n low for 1 cycle mid-burst -> all outputs 0 next cycle, no done, rr_ptr=0, new request accepted normally.

Source files
------------

// File: rtl/mem_farm_sched.sv
// mem_farm_sched: arbitrates memory requests from several clients and streams the
// granted request out as 32-byte beats spread across interleaved SRAM banks.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid/ready   per-client request handshake (ready is one-hot, IDLE only)
//   req_write         per-client direction (1 = write)
//   req_addr          per-client start byte address, client i at [i*ADDR_W +: ADDR_W]
//   req_len           per-client length in bytes, client i at [i*LEN_W +: LEN_W]
//   prio_mode         0 = fixed priority from client_priority, 1 = round-robin
//   client_priority   first client scanned in fixed mode
//   beat_*            beat stream (valid/ready handshake) with bank/row/byte count
//   done              one-cycle completion pulse for the served client
//   busy              a request is being served
module mem_farm_sched #(
  parameter int unsigned NUM_CLIENTS = 5,
  parameter int unsigned NUM_BANKS   = 16,
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned LEN_W       = 16,
  localparam int unsigned CW = $clog2(NUM_CLIENTS),
  localparam int unsigned BW = $clog2(NUM_BANKS),
  localparam int unsigned RW = ADDR_W - 5 - BW
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CLIENTS-1:0]        req_valid,
  output logic [NUM_CLIENTS-1:0]        req_ready,
  input  logic [NUM_CLIENTS-1:0]        req_write,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_CLIENTS*LEN_W-1:0]  req_len,
  input  logic                          prio_mode,
  input  logic [CW-1:0]                 client_priority,
  output logic                          beat_valid,
  input  logic                          beat_ready,
  output logic [CW-1:0]                 beat_client,
  output logic                          beat_write,
  output logic [BW-1:0]                 beat_bank,
  output logic [RW-1:0]                 beat_row,
  output logic [5:0]                    beat_bytes,
  output logic                          beat_last,
  output logic [NUM_CLIENTS-1:0]        done,
  output logic                          busy
);

  typedef enum logic [1:0] {StIdle, StBurst, StDone} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     client_q, client_d;
  logic              write_q, write_d;
  logic [BW-1:0]     bank_q, bank_d;
  logic [RW-1:0]     row_q, row_d;
  logic [LEN_W-1:0]  rem_q, rem_d;    // bytes still to send, including current beat
  logic [CW-1:0]     rr_ptr_q, rr_ptr_d;

  logic              gnt_found;
  logic [CW-1:0]     gnt_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic              in_burst;
  logic              is_last;
  logic              unused_addr_low;

  // Scan upward from the start client, wrapping; first valid client wins.
  always_comb begin
    logic [CW-1:0] start;
    int unsigned   idx;
    start     = prio_mode ? rr_ptr_q : client_priority;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      idx = (32'(start) + k) % NUM_CLIENTS;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = CW'(idx);
      end
    end
  end

  assign sel_addr        = req_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign sel_len         = req_len[gnt_idx*LEN_W +: LEN_W];
  assign unused_addr_low = ^sel_addr[4:0];

  assign in_burst = (state_q == StBurst);
  assign is_last  = (rem_q <= LEN_W'(32));

  always_comb begin
    state_d  = state_q;
    client_d = client_q;
    write_d  = write_q;
    bank_d   = bank_q;
    row_d    = row_q;
    rem_d    = rem_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          client_d = gnt_idx;
          write_d  = req_write[gnt_idx];
          bank_d   = sel_addr[5 +: BW];
          row_d    = sel_addr[ADDR_W-1 -: RW];
          rem_d    = sel_len;
          state_d  = (sel_len == '0) ? StDone : StBurst;
        end
      end
      StBurst: begin
        if (beat_ready) begin
          if (is_last) begin
            state_d = StDone;
          end else begin
            rem_d  = rem_q - LEN_W'(32);
            bank_d = bank_q + 1'b1;
            // Bank count is a power of two, so bank wraps by itself; carry into row.
            if (&bank_q) row_d = row_q + 1'b1;
          end
        end
      end
      StDone: begin
        rr_ptr_d = (client_q == CW'(NUM_CLIENTS - 1)) ? '0 : client_q + 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      client_q <= '0;
      write_q  <= 1'b0;
      bank_q   <= '0;
      row_q    <= '0;
      rem_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      client_q <= client_d;
      write_q  <= write_d;
      bank_q   <= bank_d;
      row_q    <= row_d;
      rem_q    <= rem_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // No grant while reset is asserted: the acceptance would be lost anyway.
  assign req_ready   = (state_q == StIdle && gnt_found && rst_n) ?
                       (NUM_CLIENTS'(1) << gnt_idx) : '0;
  assign beat_valid  = in_burst;
  assign beat_client = in_burst ? client_q : '0;
  assign beat_write  = in_burst & write_q;
  assign beat_bank   = in_burst ? bank_q : '0;
  assign beat_row    = in_burst ? row_q : '0;
  // rem_q is 1..32 on the final beat, so its low six bits are the byte count.
  assign beat_bytes  = in_burst ? (is_last ? rem_q[5:0] : 6'd32) : '0;
  assign beat_last   = in_burst & is_last;
  assign done        = (state_q == StDone) ? (NUM_CLIENTS'(1) << client_q) : '0;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_mem_farm_sched.sv
// Self-checking bench for mem_farm_sched: transaction-level reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_farm_sched;
  localparam int NC = 5;
  localparam int NB = 16;
  localparam int AW = 19;
  localparam int LW = 16;
  localparam int CW = 3;
  localparam int BW = 4;
  localparam int RW = AW - 5 - BW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC-1:0]     req_valid, req_ready, req_write, done;
  logic [NC*AW-1:0]  req_addr;
  logic [NC*LW-1:0]  req_len;
  logic              prio_mode;
  logic [CW-1:0]     client_priority, beat_client;
  logic              beat_valid, beat_ready, beat_write, beat_last, busy;
  logic [BW-1:0]     beat_bank;
  logic [RW-1:0]     beat_row;
  logic [5:0]        beat_bytes;

  int checks = 0;
  int errors = 0;
  bit model_en = 1'b0;

  mem_farm_sched #(.NUM_CLIENTS(NC), .NUM_BANKS(NB), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .prio_mode(prio_mode), .client_priority(client_priority),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_client(beat_client),
    .beat_write(beat_write), .beat_bank(beat_bank), .beat_row(beat_row),
    .beat_bytes(beat_bytes), .beat_last(beat_last), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int grant_of(input logic [NC-1:0] v, input int start);
    for (int k = 0; k < NC; k++) begin
      int i = (start + k) % NC;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Reference model: the current transaction as a list of beats indexed by m_k.
  int m_phase = 0;  // 0 waiting for a request, 1 streaming beats, 2 completion
  int m_client = 0, m_write = 0, m_idx0 = 0, m_len = 0, m_k = 0, m_nbeats = 0, m_rr = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (model_en) begin
        logic [NC-1:0] e_ready, e_done;
        logic [CW-1:0] e_client;
        logic [BW-1:0] e_bank;
        logic [RW-1:0] e_row;
        logic [5:0]    e_bytes;
        logic          e_bv, e_write, e_last, e_busy;
        int g, idx;
        g = -1;
        e_ready = '0; e_done = '0; e_client = '0; e_bank = '0; e_row = '0; e_bytes = '0;
        e_bv = 1'b0; e_write = 1'b0; e_last = 1'b0;
        e_busy = (m_phase != 0);
        if (m_phase == 0) begin
          g = grant_of(req_valid, prio_mode ? m_rr : int'(client_priority) % NC);
          if (g >= 0 && rst_n) e_ready = NC'(1) << g;
        end else if (m_phase == 1) begin
          idx      = m_idx0 + m_k;
          e_bv     = 1'b1;
          e_client = CW'(m_client);
          e_write  = m_write[0];
          e_bank   = BW'(idx % NB);
          e_row    = RW'((idx / NB) % (1 << RW));
          e_last   = (m_k == m_nbeats - 1);
          e_bytes  = e_last ? 6'(((m_len % 32) == 0) ? 32 : m_len % 32) : 6'd32;
        end else begin
          e_done = NC'(1) << m_client;
        end
        chk("req_ready", req_ready, e_ready);
        chk("beat_valid", beat_valid, e_bv);
        chk("beat_client", beat_client, e_client);
        chk("beat_write", beat_write, e_write);
        chk("beat_bank", beat_bank, e_bank);
        chk("beat_row", beat_row, e_row);
        chk("beat_bytes", beat_bytes, e_bytes);
        chk("beat_last", beat_last, e_last);
        chk("done", done, e_done);
        chk("busy", busy, e_busy);
        // Advance to the state after the coming rising edge (inputs are stable until then).
        if (!rst_n) begin
          m_phase = 0;
          m_rr    = 0;
        end else begin
          case (m_phase)
            0: if (g >= 0) begin
              logic [AW-1:0] a;
              a        = req_addr[g*AW +: AW];
              m_client = g;
              m_write  = int'(req_write[g]);
              m_idx0   = int'(a >> 5);
              m_len    = int'(req_len[g*LW +: LW]);
              m_nbeats = (m_len + 31) / 32;
              m_k      = 0;
              m_phase  = (m_len == 0) ? 2 : 1;
            end
            1: if (beat_ready) begin
              m_k++;
              if (m_k == m_nbeats) m_phase = 2;
            end
            default: begin
              m_rr    = (m_client + 1) % NC;
              m_phase = 0;
            end
          endcase
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input logic w, input logic [AW-1:0] a,
                         input logic [LW-1:0] l);
    req_valid[c]         = 1'b1;
    req_write[c]         = w;
    req_addr[c*AW +: AW] = a;
    req_len[c*LW +: LW]  = l;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int hs, dn;
    bit pat [12];
    rst_n = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_len = '0;
    prio_mode = 1'b0; client_priority = '0; beat_ready = 1'b1;
    tick();
    model_en = 1'b1;
    tick();
    rst_n = 1'b1;

    // Client 2, addr 0x40, len 70: banks 2,3,4 row 0, bytes 32,32,6, done at T+4.
    client_priority = 3'd2;
    set_req(2, 1'b1, 19'h00040, 16'd70);
    #1 chk("t1_ready", req_ready, 5'b00100);
    tick(); req_valid = '0;
    #1 chk("t1_b0_bank", beat_bank, 2); chk("t1_b0_bytes", beat_bytes, 32);
    chk("t1_b0_last", beat_last, 0); chk("t1_b0_row", beat_row, 0);
    tick(); #1 chk("t1_b1_bank", beat_bank, 3); chk("t1_b1_bytes", beat_bytes, 32);
    tick(); #1 chk("t1_b2_bank", beat_bank, 4); chk("t1_b2_bytes", beat_bytes, 6);
    chk("t1_b2_last", beat_last, 1);
    tick(); #1 chk("t1_done", done, 5'b00100); chk("t1_done_bv", beat_valid, 0);
    tick(); #1 chk("t1_idle_busy", busy, 0);

    // Bank 15 row 0 then bank 0 row 1.
    client_priority = 3'd0;
    set_req(0, 1'b0, 19'h001E0, 16'd64);
    #1 chk("t2_ready", req_ready, 5'b00001);
    tick(); req_valid = '0;
    #1 chk("t2_b0_bank", beat_bank, 15); chk("t2_b0_row", beat_row, 0);
    tick(); #1 chk("t2_b1_bank", beat_bank, 0); chk("t2_b1_row", beat_row, 1);
    chk("t2_b1_last", beat_last, 1);
    tick(); tick();

    // Fixed priority from 3 with 10011 picks 4; round-robin then picks 0, then 1.
    client_priority = 3'd3;
    set_req(0, 1'b0, '0, 16'd32); set_req(1, 1'b0, '0, 16'd32); set_req(4, 1'b1, '0, 16'd32);
    #1 chk("t3_fixed", req_ready, 5'b10000);
    tick(); #1 chk("t3_client", beat_client, 4);
    tick(); prio_mode = 1'b1;
    #1 chk("t3_done4", done, 5'b10000); chk("t3_no_ready_in_done", req_ready, 0);
    tick(); #1 chk("t3_rr0", req_ready, 5'b00001);
    tick(); tick(); tick(); #1 chk("t3_rr1", req_ready, 5'b00010);
    tick(); req_valid = '0;
    tick(); tick();

    // Stalled 3-beat burst: fields hold while beat_ready is low.
    prio_mode = 1'b0; client_priority = 3'd0;
    set_req(0, 1'b1, '0, 16'd96);
    #1 chk("t4_ready", req_ready, 5'b00001);
    tick(); req_valid = '0;
    foreach (pat[i]) pat[i] = 1'b1;
    pat[1] = 1'b0; pat[2] = 1'b0;
    hs = 0; dn = 0;
    for (int n = 0; n < 12; n++) begin
      beat_ready = pat[n];
      #1;
      if (beat_valid) begin
        chk("t4_bank_hold", beat_bank, hs);
        chk("t4_bytes", beat_bytes, 32);
      end
      if (beat_valid && beat_ready) hs++;
      if (done != 0) dn++;
      tick();
    end
    beat_ready = 1'b1;
    chk("t4_handshakes", hs, 3);
    chk("t4_done_pulses", dn, 1);

    // Zero-length request completes with no beats.
    client_priority = 3'd1;
    set_req(1, 1'b0, 19'h00100, 16'd0);
    #1 chk("t5_ready", req_ready, 5'b00010);
    tick(); req_valid = '0;
    #1 chk("t5_done", done, 5'b00010); chk("t5_no_beat", beat_valid, 0);
    tick(); #1 chk("t5_done_once", done, 0);

    // Reset in the middle of a burst.
    prio_mode = 1'b1;
    set_req(3, 1'b1, 19'h00080, 16'd200);
    tick(); req_valid = '0;
    tick(); tick();
    rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    #1 chk("t6_bv", beat_valid, 0); chk("t6_busy", busy, 0); chk("t6_done", done, 0);
    chk("t6_bank", beat_bank, 0); chk("t6_bytes", beat_bytes, 0); chk("t6_last", beat_last, 0);
    for (int c = 0; c < NC; c++) set_req(c, 1'b0, '0, 16'd32);
    #1 chk("t6_rr_reset", req_ready, 5'b00001);
    tick(); req_valid = '0;
    tick(); #1 chk("t6_done_after", done, 5'b00001);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      rst_n           = ($urandom_range(199) != 0);
      prio_mode       = 1'($urandom);
      client_priority = CW'($urandom_range(NC - 1));
      beat_ready      = ($urandom_range(3) != 0);
      req_valid       = NC'($urandom);
      req_write       = NC'($urandom);
      for (int c = 0; c < NC; c++) begin
        logic [AW-6:0] bi;
        logic [LW-1:0] l;
        bi = ($urandom_range(3) == 0) ? ~(AW-5)'($urandom_range(3)) : (AW-5)'($urandom);
        req_addr[c*AW +: AW] = {bi, 5'($urandom)};
        case ($urandom_range(3))
          0:       l = '0;
          1:       l = LW'(32 * $urandom_range(1, 4));
          2:       l = LW'($urandom_range(300));
          default: l = LW'($urandom_range(1, 100));
        endcase
        req_len[c*LW +: LW] = l;
      end
      tick();
    end
    rst_n = 1'b1; req_valid = '0; beat_ready = 1'b1;
    repeat (30) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
